// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: memory access encodings,
// FSM state type and small size/lane helpers.
package load_store_unit_pkg;

  localparam logic [2:0] MEM_BYTE  = 3'b000;
  localparam logic [2:0] MEM_HALF  = 3'b001;
  localparam logic [2:0] MEM_WORD  = 3'b010;
  localparam logic [2:0] MEM_BYTEU = 3'b100;
  localparam logic [2:0] MEM_HALFU = 3'b101;
  // Not a MEM_* encoding; extends to zero and enables no lanes.
  localparam logic [2:0] MEM_NONE  = 3'b111;

  typedef enum logic {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } lsu_state_t;

  function automatic logic [2:0] access_bytes(input logic [2:0] ctrl);
    case (ctrl)
      MEM_BYTE, MEM_BYTEU: return 3'd1;
      MEM_HALF, MEM_HALFU: return 3'd2;
      MEM_WORD:            return 3'd4;
      default:             return 3'd0;
    endcase
  endfunction

  function automatic logic [3:0] size_lanes(input logic [2:0] nbytes);
    case (nbytes)
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0011;
      3'd4:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Combinational load path: merges the captured first word with the live word
// for split loads, aligns by the byte offset and sign/zero-extends.
module lsu_load_extend
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] captured_word,
  input  logic        split,
  input  logic [1:0]  offset,
  input  logic [2:0]  ctrl,
  output logic [31:0] data_out
);

  logic [31:0] lo_word;
  logic [31:0] hi_word;
  logic [5:0]  sh;
  logic [31:0] aligned;

  always_comb begin
    lo_word = split ? captured_word : rd_word;
    hi_word = split ? rd_word : 32'b0;
    sh      = {1'b0, offset, 3'b000};
    // A shift by 32 yields zero, so offset 0 takes only the low word.
    aligned = (lo_word >> sh) | (hi_word << (6'd32 - sh));
    case (ctrl)
      MEM_BYTE:  data_out = {{24{aligned[7]}}, aligned[7:0]};
      MEM_BYTEU: data_out = {24'b0, aligned[7:0]};
      MEM_HALF:  data_out = {{16{aligned[15]}}, aligned[15:0]};
      MEM_HALFU: data_out = {16'b0, aligned[15:0]};
      MEM_WORD:  data_out = aligned;
      default:   data_out = 32'b0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: byte-lane stores and extended loads, with
// word-crossing accesses split into two back-to-back memory accesses.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  MEM_W_En_M,
  input  logic                  MEM_R_En_M,
  input  logic [2:0]            MEM_Control_M,
  input  logic [11:0]           ALU_Out_M,
  input  logic [31:0]           SrcB_Reg_M,
  output logic [ADDR_WIDTH-1:0] Mem_Addr,
  output logic [3:0]            Mem_W_En,
  output logic [31:0]           Mem_W_Data,
  input  logic [31:0]           Mem_R_Data,
  output logic [31:0]           Data_Out_Ext_M,
  output logic                  LSU_Stall,
  output logic [15:0]           Misaligned_Count,
  output lsu_state_t            LSU_State
);

  lsu_state_t            state_q, state_d;
  logic [2:0]            acc_ctrl_q, res_ctrl_q;
  logic [1:0]            off_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  store_q, split_q;
  logic [31:0]           captured_q;
  logic [15:0]           mis_count_q;

  logic                  req, misaligned;
  logic [ADDR_WIDTH-1:0] word_live;
  logic [1:0]            sel_off;
  logic [2:0]            sel_bytes;
  logic [7:0]            lanes_all;
  logic [63:0]           data_all;

  assign req        = MEM_W_En_M | MEM_R_En_M;
  assign misaligned = (access_bytes(MEM_Control_M) == 3'd2 && ALU_Out_M[1:0] == 2'b11) ||
                      (access_bytes(MEM_Control_M) == 3'd4 && ALU_Out_M[1:0] != 2'b00);
  assign word_live  = ADDR_WIDTH'(ALU_Out_M[11:2]);

  // Low half of the shifted lanes/data is the first access, high half the second.
  assign sel_off   = (state_q == SECOND) ? off_q : ALU_Out_M[1:0];
  assign sel_bytes = access_bytes((state_q == SECOND) ? acc_ctrl_q : MEM_Control_M);
  assign lanes_all = {4'b0000, size_lanes(sel_bytes)} << sel_off;
  assign data_all  = {32'b0, SrcB_Reg_M} << {sel_off, 3'b000};

  assign LSU_State        = state_q;
  assign Misaligned_Count = mis_count_q;

  always_comb begin
    state_d    = state_q;
    Mem_Addr   = word_live;
    Mem_W_En   = 4'b0000;
    Mem_W_Data = data_all[31:0];
    LSU_Stall  = 1'b0;
    case (state_q)
      IDLE: begin
        if (MEM_W_En_M) Mem_W_En = lanes_all[3:0];
        if (req && misaligned) begin
          LSU_Stall = 1'b1;
          state_d   = SECOND;
        end
      end
      SECOND: begin
        Mem_Addr   = addr_q + ADDR_WIDTH'(1);
        Mem_W_Data = data_all[63:32];
        if (store_q && !RST) Mem_W_En = lanes_all[7:4];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      acc_ctrl_q  <= MEM_NONE;
      res_ctrl_q  <= MEM_NONE;
      off_q       <= 2'b00;
      addr_q      <= '0;
      store_q     <= 1'b0;
      split_q     <= 1'b0;
      captured_q  <= 32'b0;
      mis_count_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        acc_ctrl_q <= MEM_Control_M;
        // A simultaneous load and store is a store: no load result follows.
        res_ctrl_q <= (MEM_R_En_M && !MEM_W_En_M) ? MEM_Control_M : MEM_NONE;
        off_q      <= ALU_Out_M[1:0];
        addr_q     <= word_live;
        store_q    <= MEM_W_En_M;
        split_q    <= req && misaligned;
        if (req && misaligned && mis_count_q != 16'hFFFF)
          mis_count_q <= mis_count_q + 16'd1;
      end else begin
        captured_q <= Mem_R_Data;
      end
    end
  end

  lsu_load_extend u_load_extend (
    .rd_word       (Mem_R_Data),
    .captured_word (captured_q),
    .split         (split_q),
    .offset        (off_q),
    .ctrl          ((state_q == SECOND) ? MEM_NONE : res_ctrl_q),
    .data_out      (Data_Out_Ext_M)
  );

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus randomized loads/stores
// checked against a byte-addressed memory model.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int AW = 10;

  logic          CLK = 1'b0;
  logic          RST;
  logic          MEM_W_En_M, MEM_R_En_M;
  logic [2:0]    MEM_Control_M;
  logic [11:0]   ALU_Out_M;
  logic [31:0]   SrcB_Reg_M;
  logic [AW-1:0] Mem_Addr;
  logic [3:0]    Mem_W_En;
  logic [31:0]   Mem_W_Data;
  logic [31:0]   Mem_R_Data;
  logic [31:0]   Data_Out_Ext_M;
  logic          LSU_Stall;
  logic [15:0]   Misaligned_Count;
  lsu_state_t    LSU_State;

  // clock / reset
  always #5 CLK = ~CLK;

  load_store_unit #(.ADDR_WIDTH(AW)) dut (
    .CLK              (CLK),
    .RST              (RST),
    .MEM_W_En_M       (MEM_W_En_M),
    .MEM_R_En_M       (MEM_R_En_M),
    .MEM_Control_M    (MEM_Control_M),
    .ALU_Out_M        (ALU_Out_M),
    .SrcB_Reg_M       (SrcB_Reg_M),
    .Mem_Addr         (Mem_Addr),
    .Mem_W_En         (Mem_W_En),
    .Mem_W_Data       (Mem_W_Data),
    .Mem_R_Data       (Mem_R_Data),
    .Data_Out_Ext_M   (Data_Out_Ext_M),
    .LSU_Stall        (LSU_Stall),
    .Misaligned_Count (Misaligned_Count),
    .LSU_State        (LSU_State)
  );

  // unified memory port A: one-cycle read latency, byte-lane writes
  logic [31:0] ram [0:(1<<AW)-1];
  always @(posedge CLK) begin
    Mem_R_Data <= ram[Mem_Addr];
    for (int i = 0; i < 4; i++)
      if (Mem_W_En[i]) ram[Mem_Addr][8*i +: 8] <= Mem_W_Data[8*i +: 8];
  end

  // reference model and scoreboard
  logic [7:0]    ref_mem [0:4095];
  logic [31:0]   exp_q[$];
  logic [15:0]   exp_count;
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [AW-1:0] c0_addr, c1_addr;
  logic [3:0]    c0_wen, c1_wen;
  logic [31:0]   c0_data, c1_data, last_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int bytes_of(input logic [2:0] ctrl);
    case (ctrl)
      MEM_BYTE, MEM_BYTEU: return 1;
      MEM_HALF, MEM_HALFU: return 2;
      MEM_WORD:            return 4;
      default:             return 0;
    endcase
  endfunction

  task automatic model_store(input logic [11:0] addr, input logic [31:0] data, input int nbytes);
    for (int i = 0; i < nbytes; i++) ref_mem[addr + 12'(i)] = data[8*i +: 8];
  endtask

  function automatic logic [31:0] model_load(input logic [11:0] addr, input logic [2:0] ctrl);
    logic [7:0] b [4];
    for (int i = 0; i < 4; i++) b[i] = ref_mem[addr + 12'(i)];
    case (ctrl)
      MEM_BYTE:  return {{24{b[0][7]}}, b[0]};
      MEM_BYTEU: return {24'b0, b[0]};
      MEM_HALF:  return {{16{b[1][7]}}, b[1], b[0]};
      MEM_HALFU: return {16'b0, b[1], b[0]};
      MEM_WORD:  return {b[3], b[2], b[1], b[0]};
      default:   return 32'b0;
    endcase
  endfunction

  // driver: one request, held through any stall, then one idle result cycle
  task automatic do_op(input logic w, input logic r, input logic [2:0] ctrl,
                       input logic [11:0] addr, input logic [31:0] data);
    bit split;
    split = (w || r) && (int'(addr[1:0]) + bytes_of(ctrl) > 4);
    MEM_W_En_M = w; MEM_R_En_M = r; MEM_Control_M = ctrl;
    ALU_Out_M = addr; SrcB_Reg_M = data;
    if (split && exp_count != 16'hFFFF) exp_count++;
    @(negedge CLK);
    c0_addr = Mem_Addr; c0_wen = Mem_W_En; c0_data = Mem_W_Data;
    check("stall_cycle0", 32'(LSU_Stall), 32'(split));
    if (!w) check("no_write_cycle0", 32'(Mem_W_En), 32'h0);
    if (split) begin
      @(posedge CLK); #1;
      @(negedge CLK);
      c1_addr = Mem_Addr; c1_wen = Mem_W_En; c1_data = Mem_W_Data;
      check("stall_cycle1", 32'(LSU_Stall), 32'h0);
    end
    if (w) model_store(addr, data, bytes_of(ctrl));
    else if (r) exp_q.push_back(model_load(addr, ctrl));
    @(posedge CLK); #1;
    MEM_W_En_M = 1'b0; MEM_R_En_M = 1'b0;
    @(negedge CLK);
    last_data = Data_Out_Ext_M;
    if (r && !w) check("load_data", Data_Out_Ext_M, exp_q.pop_front());
    else check("no_load_data", Data_Out_Ext_M, 32'h0);
    check("mis_count", 32'(Misaligned_Count), 32'(exp_count));
    @(posedge CLK); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0]  store_ctrls [5];
    logic [11:0] a;
    logic [31:0] d;
    int          kind;
    store_ctrls = '{MEM_BYTE, MEM_BYTEU, MEM_HALF, MEM_HALFU, MEM_WORD};

    // reset
    RST = 1'b1; MEM_W_En_M = 1'b0; MEM_R_En_M = 1'b0; MEM_Control_M = MEM_WORD;
    ALU_Out_M = 12'h0; SrcB_Reg_M = 32'h0; exp_count = 16'h0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset_state", 32'(LSU_State), 32'(IDLE));
    check("reset_count", 32'(Misaligned_Count), 32'h0);
    check("reset_stall", 32'(LSU_Stall), 32'h0);
    check("reset_wen", 32'(Mem_W_En), 32'h0);
    check("reset_data_out", Data_Out_Ext_M, 32'h0);
    @(posedge CLK); #1;
    RST = 1'b0;

    // prefill the two address windows used below
    for (int k = 0; k < 16; k++) do_op(1'b1, 1'b0, MEM_WORD, 12'(4 * k), $urandom);
    for (int k = 0; k < 16; k++) do_op(1'b1, 1'b0, MEM_WORD, 12'hFC0 + 12'(4 * k), $urandom);

    // aligned word store and load
    do_op(1'b1, 1'b0, MEM_WORD, 12'h010, 32'hDEADBEEF);
    check("sw_aligned_addr", 32'(c0_addr), 32'd4);
    check("sw_aligned_wen", 32'(c0_wen), 32'hF);
    check("sw_aligned_data", c0_data, 32'hDEADBEEF);
    do_op(1'b0, 1'b1, MEM_WORD, 12'h010, 32'h0);
    check("lw_aligned_result", last_data, 32'hDEADBEEF);

    // split store
    do_op(1'b1, 1'b0, MEM_WORD, 12'h011, 32'h11223344);
    check("split_sw_c0_addr", 32'(c0_addr), 32'd4);
    check("split_sw_c0_wen", 32'(c0_wen), 32'hE);
    check("split_sw_c0_data", c0_data, 32'h22334400);
    check("split_sw_c1_addr", 32'(c1_addr), 32'd5);
    check("split_sw_c1_wen", 32'(c1_wen), 32'h1);
    check("split_sw_c1_data", c1_data, 32'h00000011);
    check("split_sw_count", 32'(Misaligned_Count), 32'd1);

    // split halfword loads, signed and unsigned
    do_op(1'b1, 1'b0, MEM_WORD, 12'h010, 32'h8899AABB);
    do_op(1'b1, 1'b0, MEM_WORD, 12'h014, 32'hCCDDEEFF);
    do_op(1'b0, 1'b1, MEM_HALF, 12'h013, 32'h0);
    check("lh_split_result", last_data, 32'hFFFFFF88);
    do_op(1'b0, 1'b1, MEM_HALFU, 12'h013, 32'h0);
    check("lhu_split_result", last_data, 32'h0000FF88);

    // store wrapping past the top of memory
    do_op(1'b1, 1'b0, MEM_WORD, 12'hFFF, 32'hA1B2C3D4);
    check("wrap_c0_addr", 32'(c0_addr), 32'h3FF);
    check("wrap_c0_wen", 32'(c0_wen), 32'h8);
    check("wrap_c1_addr", 32'(c1_addr), 32'h0);
    check("wrap_c1_wen", 32'(c1_wen), 32'h7);
    do_op(1'b0, 1'b1, MEM_WORD, 12'hFFF, 32'h0);
    check("wrap_lw_result", last_data, 32'hA1B2C3D4);

    // load and store together behave as a store
    do_op(1'b1, 1'b1, MEM_WORD, 12'h018, 32'h5A5A1234);
    do_op(1'b0, 1'b1, MEM_WORD, 12'h018, 32'h0);
    check("both_then_lw", last_data, 32'h5A5A1234);

    // reset during the second access of a split store
    d = 32'hCAFEF00D;
    MEM_W_En_M = 1'b1; MEM_R_En_M = 1'b0; MEM_Control_M = MEM_WORD;
    ALU_Out_M = 12'h021; SrcB_Reg_M = d;
    @(negedge CLK);
    check("rst_split_c0_stall", 32'(LSU_Stall), 32'h1);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(negedge CLK);
    check("rst_split_c1_wen", 32'(Mem_W_En), 32'h0);
    check("rst_split_c1_stall", 32'(LSU_Stall), 32'h0);
    @(posedge CLK); #1;
    RST = 1'b0; MEM_W_En_M = 1'b0;
    @(negedge CLK);
    check("rst_split_state", 32'(LSU_State), 32'(IDLE));
    check("rst_split_count", 32'(Misaligned_Count), 32'h0);
    exp_count = 16'h0;
    model_store(12'h021, d, 3);
    @(posedge CLK); #1;
    do_op(1'b0, 1'b1, MEM_WORD, 12'h020, 32'h0);
    do_op(1'b0, 1'b1, MEM_WORD, 12'h024, 32'h0);

    // randomized traffic inside the prefilled windows
    for (int k = 0; k < 150; k++) begin
      kind = $urandom_range(0, 4);
      if ($urandom_range(0, 1) == 1) a = 12'hFC0 + 12'($urandom_range(0, 63));
      else a = 12'($urandom_range(0, 59));
      d = $urandom;
      case (kind)
        0:       do_op(1'b1, 1'b0, store_ctrls[$urandom_range(0, 4)], a, d);
        1, 2:    do_op(1'b0, 1'b1, 3'($urandom_range(0, 7)), a, d);
        3:       do_op(1'b1, 1'b1, store_ctrls[$urandom_range(0, 4)], a, d);
        default: do_op(1'b0, 1'b0, 3'($urandom_range(0, 7)), a, d);
      endcase
    end

    // counter saturation
    force dut.mis_count_q = 16'hFFFF;
    @(posedge CLK); #1;
    release dut.mis_count_q;
    exp_count = 16'hFFFF;
    @(negedge CLK);
    check("sat_preload", 32'(Misaligned_Count), 32'hFFFF);
    @(posedge CLK); #1;
    do_op(1'b0, 1'b1, MEM_WORD, 12'h005, 32'h0);
    check("sat_after_split", 32'(Misaligned_Count), 32'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
